stream_inject: RTL and testbench

Node-side injector that packs core payloads into router stream words, {naddr, data} with the destination network address in the top net_width bits. It sits between a neuron core and the local input port of a NodeRouter, buffering words in a small FIFO and presenting them with a valid/ready handshake. Words addressed to the node itself are diverted to a local loopback port instead of the router.

---
 rtl/router_pkg.sv | 15 +
 rtl/stream_fifo.sv | 42 ++++
 rtl/stream_inject.sv | 73 +++++++
 tb/tb_stream_inject.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router stream definitions: default field widths and word helpers.
package router_pkg;

  localparam int unsigned default_net_width    = 4;
  localparam int unsigned default_data_width   = 128;
  localparam int unsigned default_stream_width = default_data_width + default_net_width;

  // Destination address sits in the top net_width bits of a stream word.
  function automatic logic [default_net_width-1:0] naddr_of(
    input logic [default_stream_width-1:0] word
  );
    return word[default_stream_width-1 -: default_net_width];
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small FIFO of stream words; head entry is read straight out of storage.
module stream_fifo #(
  parameter int unsigned width = 132,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [aw:0]      wptr;
  logic [aw:0]      rptr;
  logic [width-1:0] mem [depth];

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
  assign head  = mem[rptr[aw-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + ptr_one;
      if (pop && !empty) rptr <= rptr + ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[aw-1:0]] <= push_data;
  end

endmodule

// File: rtl/stream_inject.sv
// Node-side injector: buffers core words toward the router, diverting
// self-addressed words to a one-entry loopback register.
module stream_inject
  import router_pkg::*;
#(
  parameter int unsigned net_width    = default_net_width,
  parameter int unsigned data_width   = default_data_width,
  parameter int unsigned stream_width = data_width + net_width,
  parameter int unsigned depth        = 4,
  parameter logic [net_width-1:0] self_addr = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_valid,
  output logic                    core_ready,
  input  logic [net_width-1:0]    core_dest,
  input  logic [data_width-1:0]   core_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [stream_width-1:0] out_stream,
  output logic                    loop_valid,
  input  logic                    loop_ready,
  output logic [data_width-1:0]   loop_data,
  output logic [15:0]             sent_count
);

  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic is_self;
  logic push;
  logic pop;

  // Ready deliberately ignores core_dest so it stays register-derived.
  assign core_ready = !fifo_full && !loop_valid;
  assign accept     = core_valid && core_ready;
  assign is_self    = (core_dest == self_addr);
  assign push       = accept && !is_self;
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;

  stream_fifo #(
    .width (stream_width),
    .depth (depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({core_dest, core_data}),
    .pop       (pop),
    .head      (out_stream),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_valid <= 1'b0;
      loop_data  <= '0;
    end else if (accept && is_self) begin
      loop_valid <= 1'b1;
      loop_data  <= core_data;
    end else if (loop_valid && loop_ready) begin
      loop_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sent_count <= '0;
    else if (pop) sent_count <= sent_count + 16'd1;
  end

endmodule

// File: tb/tb_stream_inject.sv
// Directed bench for stream_inject with hand-computed expectations.
module tb_stream_inject;
  import router_pkg::*;

  localparam int unsigned sw = default_stream_width;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            core_valid = 1'b0;
  logic            core_ready;
  logic [3:0]      core_dest = '0;
  logic [127:0]    core_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [sw-1:0]   out_stream;
  logic            loop_valid;
  logic            loop_ready = 1'b0;
  logic [127:0]    loop_data;
  logic [15:0]     sent_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [sw-1:0] sb[$];
  logic [sw-1:0] words [5];
  int unsigned   occ;
  logic          exp_ready;

  always #5 clk = ~clk;

  stream_inject #(
    .net_width  (4),
    .data_width (128),
    .depth      (4),
    .self_addr  (4'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .core_dest  (core_dest),
    .core_data  (core_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_stream (out_stream),
    .loop_valid (loop_valid),
    .loop_ready (loop_ready),
    .loop_data  (loop_data),
    .sent_count (sent_count)
  );

  task automatic check(input string tag, input logic [sw-1:0] got, input logic [sw-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    core_valid = 1'b0;
    out_ready  = 1'b0;
    loop_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic offer(input logic [3:0] d, input logic [127:0] x);
    core_valid = 1'b1;
    core_dest  = d;
    core_data  = x;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_out_valid", sw'(out_valid), sw'(0));
    check("rst_core_ready", sw'(core_ready), sw'(1));
    check("rst_loop_valid", sw'(loop_valid), sw'(0));
    check("rst_sent", sw'(sent_count), sw'(0));

    // Single word, one-cycle inject latency
    out_ready = 1'b1;
    offer(4'h3, 128'hA5);
    step();
    core_valid = 1'b0;
    check("single_valid", sw'(out_valid), sw'(1));
    check("single_stream", out_stream, {4'h3, 128'hA5});
    check("single_naddr", sw'(naddr_of(out_stream)), sw'(4'h3));
    check("single_sent0", sw'(sent_count), sw'(0));
    step();
    check("single_sent1", sw'(sent_count), sw'(1));
    check("single_empty", sw'(out_valid), sw'(0));

    // Fill to full with out_ready low, then drain
    do_reset();
    for (int unsigned i = 0; i < 5; i++)
      words[i] = {4'(i + 1), 128'(32'h100 + i)};
    for (int unsigned i = 0; i < 5; i++) begin
      offer(words[i][131:128], words[i][127:0]);
      check($sformatf("fill_ready%0d", i), sw'(core_ready), sw'(i < 4 ? 1 : 0));
      if (i < 4) step();
    end
    check("full_out_valid", sw'(out_valid), sw'(1));
    check("full_head", out_stream, words[0]);
    out_ready = 1'b1;
    step();
    check("drain_ready_back", sw'(core_ready), sw'(1));
    check("drain_head1", out_stream, words[1]);
    check("drain_sent1", sw'(sent_count), sw'(1));
    step();
    core_valid = 1'b0;
    for (int unsigned k = 2; k < 5; k++) begin
      check($sformatf("drain_head%0d", k), out_stream, words[k]);
      step();
    end
    check("drain_empty", sw'(out_valid), sw'(0));
    check("drain_sent5", sw'(sent_count), sw'(5));

    // Self-addressed word goes to loopback
    do_reset();
    offer(4'h0, 128'hDEAD_BEEF);
    step();
    core_valid = 1'b0;
    check("loop_valid", sw'(loop_valid), sw'(1));
    check("loop_data", sw'(loop_data), sw'(128'hDEAD_BEEF));
    check("loop_core_ready", sw'(core_ready), sw'(0));
    check("loop_out_valid", sw'(out_valid), sw'(0));
    step();
    check("loop_hold", sw'(loop_valid), sw'(1));
    check("loop_data_hold", sw'(loop_data), sw'(128'hDEAD_BEEF));
    loop_ready = 1'b1;
    step();
    loop_ready = 1'b0;
    check("loop_cleared", sw'(loop_valid), sw'(0));
    check("loop_ready_back", sw'(core_ready), sw'(1));
    check("loop_no_out", sw'(out_valid), sw'(0));

    // Steady push/pop at half occupancy against a scoreboard
    do_reset();
    sb.delete();
    for (int unsigned i = 0; i < 2; i++) begin
      offer(4'h5, 128'(32'hC000 + i));
      sb.push_back({4'h5, 128'(32'hC000 + i)});
      step();
    end
    occ = 2;
    out_ready = 1'b1;
    for (int unsigned c = 0; c < 100; c++) begin
      offer(4'(c % 15 + 1), {96'h0, 32'(c * 7 + 3)});
      exp_ready = (occ < 4);
      check("steady_ready", sw'(core_ready), sw'(exp_ready));
      check("steady_valid", sw'(out_valid), sw'(occ > 0));
      check("steady_data", out_stream, sb[0]);
      step();
      void'(sb.pop_front());
      if (exp_ready) sb.push_back({core_dest, core_data});
      else occ--;
    end
    core_valid = 1'b0;
    for (int unsigned n = 0; n < 6 && sb.size() > 0; n++) begin
      check("steady_drain", out_stream, sb.pop_front());
      step();
    end
    check("steady_sb_empty", sw'(sb.size()), sw'(0));
    check("steady_end_empty", sw'(out_valid), sw'(0));
    check("steady_sent", sw'(sent_count), sw'(102));

    // Asynchronous reset with words buffered
    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      offer(4'h7, 128'(i));
      step();
    end
    core_valid = 1'b0;
    out_ready  = 1'b1;
    step();
    out_ready  = 1'b0;
    check("prerst_sent", sw'(sent_count), sw'(1));
    check("prerst_valid", sw'(out_valid), sw'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", sw'(out_valid), sw'(0));
    check("async_sent", sw'(sent_count), sw'(0));
    check("async_core_ready", sw'(core_ready), sw'(1));
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("postrst_no_stale", sw'(out_valid), sw'(0));
    check("postrst_sent", sw'(sent_count), sw'(0));

    // sent_count wrap
    do_reset();
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 65534; i++) begin
      offer(4'h9, 128'(i));
      step();
    end
    core_valid = 1'b0;
    step();
    check("wrap_fffe", sw'(sent_count), sw'(16'hFFFE));
    offer(4'h9, 128'h1);
    step();
    core_valid = 1'b0;
    step();
    check("wrap_ffff", sw'(sent_count), sw'(16'hFFFF));
    offer(4'h9, 128'h2);
    step();
    core_valid = 1'b0;
    step();
    check("wrap_zero", sw'(sent_count), sw'(16'h0000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
